// File: rtl/dbus_mmio_pkg.sv
// Shared register map, bit positions and status layout for the data-bus MMIO responder.
package dbus_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  // Word-aligned register offsets within the 256-byte region
  localparam logic [7:0] OFF_TXDATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_MTIME    = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP = 8'h0C;
  localparam logic [7:0] OFF_IRQCTL   = 8'h10;

  // STATUS bit positions
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 4;

  // IRQCTL bit positions
  localparam int unsigned IRQ_EN   = 0;
  localparam int unsigned IRQ_PEND = 1;

  // Low byte of the STATUS read word
  typedef struct packed {
    logic [3:0] count;
    logic       rsvd;
    logic       overflow;
    logic       full;
    logic       empty;
  } status_t;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO for the console TX path; a push while full is accepted only if a pop frees a slot the same cycle.
module mmio_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = CNT_W - 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;
  logic [CNT_W-1:0] count_nxt;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop cancel out
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers and registered full/empty flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/dbus_mmio_responder.sv
// MMIO responder on the core data bus: console TX FIFO, cycle timer with compare, timer interrupt.
module dbus_mmio_responder
  import dbus_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic        hit,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  logic [7:0]       off;
  logic             wr;
  logic             wr_tx;
  logic             wr_status;
  logic             wr_mtime;
  logic             wr_mtimecmp;
  logic             wr_irqctl;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [31:0]      mtime;
  logic [31:0]      mtimecmp;
  logic             enable;
  logic             pending;
  logic             match;
  status_t          status;
  logic             unused_addr;

  assign unused_addr = ^addr[1:0];

  // Address decode: region on addr[31:8], register on the word index
  assign off         = {addr[7:2], 2'b00};
  assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr          = memwrite && hit;
  assign wr_tx       = wr && (off == OFF_TXDATA);
  assign wr_status   = wr && (off == OFF_STATUS);
  assign wr_mtime    = wr && (off == OFF_MTIME);
  assign wr_mtimecmp = wr && (off == OFF_MTIMECMP);
  assign wr_irqctl   = wr && (off == OFF_IRQCTL);

  assign tx_valid  = !fifo_empty;
  assign pop       = tx_valid && tx_ready;
  assign match     = (mtime == mtimecmp);
  assign timer_irq = pending && enable;

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (writedata[7:0]),
    .pop       (pop),
    .rd_data   (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow: set by a dropped push, cleared by writing 1 to its STATUS bit
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_tx && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (wr_status && writedata[ST_OVF]) begin
      overflow <= 1'b0;
    end
  end

  // Free-running timer; a software load replaces the increment for that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= 32'hFFFF_FFFF;
    end else begin
      mtime <= wr_mtime ? writedata : mtime + 32'd1;
      if (wr_mtimecmp) mtimecmp <= writedata;
    end
  end

  // Interrupt enable and pending; a match outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_irqctl) enable <= writedata[IRQ_EN];
      if (match) begin
        pending <= 1'b1;
      end else if (wr_irqctl && writedata[IRQ_PEND]) begin
        pending <= 1'b0;
      end
    end
  end

  // STATUS byte assembly
  always_comb begin
    status          = '0;
    status.empty    = fifo_empty;
    status.full     = fifo_full;
    status.overflow = overflow;
    status.count    = 4'(fifo_count);
  end

  // Zero-wait-state read mux; zero outside the region and at unmapped offsets
  always_comb begin
    readdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS:   readdata = {24'b0, status};
        OFF_MTIME:    readdata = mtime;
        OFF_MTIMECMP: readdata = mtimecmp;
        OFF_IRQCTL:   readdata = {30'b0, pending, enable};
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_mmio_responder.sv
// Self-checking bench for dbus_mmio_responder against a queue-based reference model.
module tb_dbus_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic        tx_ready = 1'b0;
  logic        hit;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0;
  logic        m_en = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_mtime = '0;
  logic [31:0] m_cmp = 32'hFFFF_FFFF;

  dbus_mmio_responder dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .hit       (hit),
    .readdata  (readdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int o;
    if (!m_hit(a)) return 32'h0;
    o = int'(a[7:2]) * 4;
    case (o)
      4:  return (mq.size() * 16) + (m_ovf ? 4 : 0) +
                 (mq.size() == DEPTH ? 2 : 0) + (mq.size() == 0 ? 1 : 0);
      8:  return m_mtime;
      12: return m_cmp;
      16: return {30'b0, m_pend, m_en};
      default: return 32'h0;
    endcase
  endfunction

  // Apply one clock edge's worth of register-map rules to the model
  task automatic model_edge();
    logic w;
    int   o;
    logic do_pop;
    int   sz;
    w = memwrite && m_hit(addr);
    o = int'(addr[7:2]) * 4;
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_en = 0; m_pend = 0;
      m_mtime = 0; m_cmp = 32'hFFFF_FFFF;
      return;
    end
    sz = mq.size();
    do_pop = tx_ready && (sz > 0);
    if (m_mtime == m_cmp) m_pend = 1;
    else if (w && o == 16 && writedata[1]) m_pend = 0;
    if (w && o == 16) m_en = writedata[0];
    m_mtime = (w && o == 8) ? writedata : m_mtime + 1;
    if (w && o == 12) m_cmp = writedata;
    if (do_pop) void'(mq.pop_front());
    if (w && o == 0) begin
      if (sz < DEPTH || do_pop) mq.push_back(writedata[7:0]);
      else m_ovf = 1;
    end
    if (w && o == 4 && writedata[2]) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; memwrite = 1'b0;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus_read(BASE + 32'h04, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
    bus_read(BASE + 32'h0C, d);
    n_checks++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_mtimecmp: got %h expected %h", d, 32'hFFFF_FFFF); end
    n_checks++;
    if (tx_valid !== 1'b0 || timer_irq !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b irq=%b data=%h expected 0 0 00", tx_valid, timer_irq, tx_data);
    end
  endtask

  task automatic test_fifo_order();
    logic [7:0]  exp_b [3];
    logic [31:0] d;
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(BASE, 32'(exp_b[i]) | 32'hABCD_0000);
    bus_read(BASE + 32'h04, d);
    n_checks++;
    if (d !== 32'h30) begin n_fail++; $display("FAIL fifo_status3: got %h expected %h", d, 32'h30); end
    n_checks++;
    if (tx_data !== 8'h41) begin n_fail++; $display("FAIL fifo_head: got %h expected %h", tx_data, 8'h41); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        n_fail++;
        $display("FAIL fifo_drain%0d: got valid=%b data=%h expected 1 %h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty_after: got %b expected 0", tx_valid); end
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [7:0]  b [5];
    logic [7:0]  exp_b [4];
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom_range(1, 254));
      bus_write(BASE, 32'(b[i]));
    end
    bus_read(BASE + 32'h04, d);
    n_checks++;
    if (d !== 32'h46) begin n_fail++; $display("FAIL ovf_status: got %h expected %h", d, 32'h46); end
    bus_write(BASE + 32'h04, 32'h4);
    bus_read(BASE + 32'h04, d);
    n_checks++;
    if (d !== 32'h42) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h42); end
    // full: push and pop in the same cycle
    tx_ready = 1'b1;
    bus_write(BASE, 32'h55);
    tx_ready = 1'b0;
    bus_read(BASE + 32'h04, d);
    n_checks++;
    if (d !== 32'h42) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected %h", d, 32'h42); end
    exp_b[0] = b[1]; exp_b[1] = b[2]; exp_b[2] = b[3]; exp_b[3] = 8'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        n_fail++;
        $display("FAIL full_drain%0d: got valid=%b data=%h expected 1 %h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_end: got %b expected 0", tx_valid); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int          cyc;
    bus_write(BASE + 32'h10, 32'h2);
    bus_write(BASE + 32'h08, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h0C, 32'h0000_0001);
    bus_write(BASE + 32'h10, 32'h1);
    bus_read(BASE + 32'h08, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL timer_wrap: got %h expected %h", d, 32'h0); end
    cyc = 0;
    while (timer_irq !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    n_checks++;
    if (cyc !== 2) begin n_fail++; $display("FAIL timer_irq_latency: got %0d expected %0d", cyc, 2); end
    bus_read(BASE + 32'h10, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL timer_irqctl: got %h expected %h", d, 32'h3); end
    bus_write(BASE + 32'h10, 32'h3);
    bus_read(BASE + 32'h10, d);
    n_checks++;
    if (timer_irq !== 1'b0 || d !== 32'h1) begin
      n_fail++;
      $display("FAIL timer_clear: got irq=%b irqctl=%h expected 0 %h", timer_irq, d, 32'h1);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] before_cmp;
    logic [31:0] before_irq;
    logic [31:0] before_st;
    before_cmp = m_read(BASE + 32'h0C);
    before_irq = m_read(BASE + 32'h10);
    before_st  = m_read(BASE + 32'h04);
    bus_write(BASE + 32'h20, $urandom);
    bus_write(32'h0000_0018, $urandom);
    bus_write(32'h0000_000C, 32'h1234_5678);
    bus_read(32'h0000_0018, d);
    n_checks++;
    if (hit !== 1'b0 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL decode_nohit: got hit=%b data=%h expected 0 0", hit, d);
    end
    bus_read(BASE + 32'h20, d);
    n_checks++;
    if (hit !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL decode_unmapped: got hit=%b data=%h expected 1 0", hit, d);
    end
    bus_read(BASE + 32'h0C, d);
    n_checks++;
    if (d !== before_cmp) begin n_fail++; $display("FAIL decode_cmp_kept: got %h expected %h", d, before_cmp); end
    bus_read(BASE + 32'h10, d);
    n_checks++;
    if (d !== before_irq) begin n_fail++; $display("FAIL decode_irq_kept: got %h expected %h", d, before_irq); end
    bus_read(BASE + 32'h04, d);
    n_checks++;
    if (d !== before_st) begin n_fail++; $display("FAIL decode_status_kept: got %h expected %h", d, before_st); end
  endtask

  task automatic test_random();
    logic [31:0] offs [7];
    logic [31:0] exp_rd;
    offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08; offs[3] = 32'h0C;
    offs[4] = 32'h10; offs[5] = 32'h20; offs[6] = 32'h07;
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      tx_ready = ($urandom_range(0, 2) == 0);
      memwrite = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = BASE | offs[$urandom_range(0, 6)];
      writedata = $urandom;
      if (addr[7:0] == 8'h08 && $urandom_range(0, 3) != 0) writedata = m_mtime + 32'd3;
      if (addr[7:0] == 8'h0C) writedata = m_mtime + 32'($urandom_range(1, 12));
      #1;
      exp_rd = m_read(addr);
      n_checks++;
      if (hit !== m_hit(addr) || readdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rand_read%0d: got hit=%b data=%h expected %b %h", n, hit, readdata, m_hit(addr), exp_rd);
      end
      n_checks++;
      if (tx_valid !== (mq.size() > 0) || (mq.size() > 0 && tx_data !== mq[0])) begin
        n_fail++;
        $display("FAIL rand_tx%0d: got valid=%b data=%h expected %b %h", n, tx_valid, tx_data,
                 mq.size() > 0, (mq.size() > 0) ? mq[0] : 8'h00);
      end
      n_checks++;
      if (timer_irq !== (m_pend && m_en)) begin
        n_fail++;
        $display("FAIL rand_irq%0d: got %b expected %b", n, timer_irq, m_pend && m_en);
      end
      tick();
    end
    reset = 1'b0; memwrite = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow_and_full_pushpop();
    test_timer();
    test_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
